// File: rtl/mips_lsu_pkg.sv
// Shared types and decode helpers for the MIPS load/store unit controller.
package mips_lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } lsu_state_t;

    function automatic logic lsu_is_store(input lsu_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [3:0] lsu_byteenable(input lsu_op_t op, input logic [1:0] addr);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 4'b0001 << addr;
            OP_LH, OP_LHU, OP_SH: return addr[1] ? 4'b1100 : 4'b0011;
            default:              return 4'b1111;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input lsu_op_t op, input logic [1:0] addr);
        case (op)
            OP_LH, OP_LHU, OP_SH: return addr[0];
            OP_LW, OP_SW:         return addr != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    // Stores replicate the datum across every lane it could occupy; byteenable selects.
    function automatic logic [31:0] lsu_writedata(input lsu_op_t op, input logic [31:0] wdata);
        case (op)
            OP_SB:   return {4{wdata[7:0]}};
            OP_SH:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_load_align.sv
// Load data alignment: shifts the addressed lane down and sign/zero-extends it.
module mips_cpu_lsu_load_align
    import mips_lsu_pkg::*;
(
    input  logic [31:0] readdata,
    input  logic [1:0]  addr,
    input  lsu_op_t     op,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = readdata >> {addr, 3'b000};
        data    = '0;
        case (op)
            OP_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  data = {24'h000000, shifted[7:0]};
            OP_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  data = {16'h0000, shifted[15:0]};
            OP_LW:   data = readdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu_ctrl.sv
// Load/store unit controller: sequences one request at a time onto an Avalon-style
// data bus, holding it across waitrequest, and returns extended load data.
module mips_cpu_lsu_ctrl
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_waitrequest
);

    lsu_state_t  state;
    lsu_op_t     op_q;
    logic [1:0]  addr_lo_q;
    lsu_op_t     req_op_t;
    logic [31:0] load_data;

    assign req_op_t  = lsu_op_t'(req_op);
    assign req_ready = (state == ST_IDLE);

    mips_cpu_lsu_load_align u_load_align (
        .readdata (mem_readdata),
        .addr     (addr_lo_q),
        .op       (op_q),
        .data     (load_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            op_q           <= OP_LB;
            addr_lo_q      <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            mem_address    <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op_t;
                        addr_lo_q <= req_addr[1:0];
                        // Misaligned requests skip the bus entirely and answer next cycle.
                        if (lsu_misaligned(req_op_t, req_addr[1:0])) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state          <= ST_BUS;
                            mem_address    <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_byteenable <= lsu_byteenable(req_op_t, req_addr[1:0]);
                            mem_writedata  <= lsu_writedata(req_op_t, req_wdata);
                            mem_read       <= !lsu_is_store(req_op_t);
                            mem_write      <= lsu_is_store(req_op_t);
                        end
                    end
                end
                ST_BUS: begin
                    if (!mem_waitrequest) begin
                        state          <= ST_RESP;
                        mem_read       <= 1'b0;
                        mem_write      <= 1'b0;
                        mem_byteenable <= '0;
                        rsp_valid      <= 1'b1;
                        rsp_err        <= 1'b0;
                        rsp_rdata      <= load_data;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_lsu_ctrl.sv
// Directed bench for mips_cpu_lsu_ctrl with a response scoreboard.
module tb_mips_cpu_lsu_ctrl;
    import mips_lsu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        lsu_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [31:0] exp_rdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] exp_wd;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   total;
    int   bad;

    mips_cpu_lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns in cycle N+1.
    task automatic issue(input lsu_op_t op, input logic [31:0] a, input logic [31:0] wd);
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        chk("ready_at_issue", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int start, input int exp_lat);
        int   cyc;
        exp_t e;
        cyc = start;
        while (!rsp_valid && cyc < 30) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, rsp_rdata, e.rdata);
            chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
        end
        tick();
        chk({tag, "_pulse_end"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rdata_idle"}, rsp_rdata, 32'd0);
    endtask

    initial begin
        int seen;
        total           = 0;
        bad             = 0;
        reset_n         = 1'b0;
        req_valid       = 1'b0;
        req_op          = 3'd0;
        req_addr        = '0;
        req_wdata       = '0;
        mem_readdata    = '0;
        mem_waitrequest = 1'b0;

        vecs[0] = '{OP_LBU, 32'h0000_0001, 32'h0, 32'h0000_8000, 32'h0000_0080, 1'b0, 4'b0010, 32'h0};
        vecs[1] = '{OP_LB,  32'h0000_0002, 32'h0, 32'h007F_0000, 32'h0000_007F, 1'b0, 4'b0100, 32'h0};
        vecs[2] = '{OP_LH,  32'h0000_0002, 32'h0, 32'h8000_0000, 32'hFFFF_8000, 1'b0, 4'b1100, 32'h0};
        vecs[3] = '{OP_LW,  32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0};
        vecs[4] = '{OP_SW,  32'h0000_000C, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0, 4'b1111, 32'hCAFE_F00D};
        vecs[5] = '{OP_SH,  32'h0000_0003, 32'h1111_2222, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0};
        vecs[6] = '{OP_LHU, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 4'b0000, 32'h0};

        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("rst_byteenable", 32'(mem_byteenable), 32'd0);
        chk("rst_address", mem_address, 32'd0);
        chk("rst_writedata", mem_writedata, 32'd0);
        #3 reset_n = 1'b1;
        tick();

        // LB, top lane, sign-extended
        mem_readdata    = 32'h8012_3456;
        mem_waitrequest = 1'b0;
        issue(OP_LB, 32'h0000_1003, 32'h0);
        chk("lb_read", 32'(mem_read), 32'd1);
        chk("lb_write", 32'(mem_write), 32'd0);
        chk("lb_be", 32'(mem_byteenable), 32'h8);
        chk("lb_addr", mem_address, 32'h0000_1000);
        exp_q.push_back('{32'hFFFF_FF80, 1'b0});
        wait_rsp("lb", 1, 2);

        // LHU with three wait states
        mem_readdata    = 32'hBEEF_0000;
        mem_waitrequest = 1'b1;
        issue(OP_LHU, 32'h0000_2002, 32'h0);
        exp_q.push_back('{32'h0000_BEEF, 1'b0});
        for (int i = 0; i < 3; i++) begin
            chk("lhu_read_hold", 32'(mem_read), 32'd1);
            chk("lhu_be_hold", 32'(mem_byteenable), 32'hC);
            chk("lhu_addr_hold", mem_address, 32'h0000_2000);
            tick();
        end
        mem_waitrequest = 1'b0;
        chk("lhu_read_last", 32'(mem_read), 32'd1);
        wait_rsp("lhu", 4, 5);

        // SB lane replication
        issue(OP_SB, 32'h0000_3001, 32'h0000_00A5);
        chk("sb_write", 32'(mem_write), 32'd1);
        chk("sb_read", 32'(mem_read), 32'd0);
        chk("sb_be", 32'(mem_byteenable), 32'h2);
        chk("sb_wdata", mem_writedata, 32'hA5A5_A5A5);
        exp_q.push_back('{32'h0, 1'b0});
        wait_rsp("sb", 1, 2);

        // Misaligned LW: no bus activity
        issue(OP_LW, 32'h0000_4002, 32'h0);
        chk("lw_mis_strobes", 32'({mem_read, mem_write}), 32'd0);
        exp_q.push_back('{32'h0, 1'b1});
        wait_rsp("lw_mis", 1, 1);

        // Reset while stalled in BUS
        mem_waitrequest = 1'b1;
        issue(OP_LW, 32'h0000_5000, 32'h0);
        chk("rstmid_read_before", 32'(mem_read), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("rstmid_strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("rstmid_be", 32'(mem_byteenable), 32'd0);
        chk("rstmid_addr", mem_address, 32'd0);
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        tick();
        #3 reset_n = 1'b1;
        mem_waitrequest = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid || mem_read) seen++;
        end
        chk("rstmid_no_rsp", 32'(seen), 32'd0);
        chk("rstmid_ready_after", 32'(req_ready), 32'd1);

        // Back-to-back LH then SH, second held valid until accepted
        mem_readdata = 32'h0000_8001;
        issue(OP_LH, 32'h0000_0010, 32'h0);
        exp_q.push_back('{32'hFFFF_8001, 1'b0});
        req_op    = OP_SH;
        req_addr  = 32'h0000_0012;
        req_wdata = 32'h0000_1234;
        req_valid = 1'b1;
        chk("b2b_busy", 32'(req_ready), 32'd0);
        wait_rsp("b2b_lh", 1, 2);
        issue(OP_SH, 32'h0000_0012, 32'h0000_1234);
        chk("b2b_sh_write", 32'(mem_write), 32'd1);
        chk("b2b_sh_be", 32'(mem_byteenable), 32'hC);
        chk("b2b_sh_wdata", mem_writedata, 32'h1234_1234);
        chk("b2b_sh_addr", mem_address, 32'h0000_0010);
        exp_q.push_back('{32'h0, 1'b0});
        wait_rsp("b2b_sh", 1, 2);

        // Table of further ops
        for (int v = 0; v < 7; v++) begin
            mem_readdata = vecs[v].rd;
            issue(vecs[v].op, vecs[v].addr, vecs[v].wdata);
            if (vecs[v].err) begin
                chk("vec_err_strobes", 32'({mem_read, mem_write}), 32'd0);
            end else begin
                chk("vec_be", 32'(mem_byteenable), 32'(vecs[v].be));
                chk("vec_addr", mem_address, vecs[v].addr & 32'hFFFF_FFFC);
                chk("vec_strobe", 32'({mem_read, mem_write}),
                    lsu_is_store(vecs[v].op) ? 32'd1 : 32'd2);
                if (lsu_is_store(vecs[v].op))
                    chk("vec_wdata", mem_writedata, vecs[v].exp_wd);
            end
            exp_q.push_back('{vecs[v].exp_rdata, vecs[v].err});
            wait_rsp("vec", 1, vecs[v].err ? 1 : 2);
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_cpu_lsu_ctrl.md
# mips_cpu_lsu_ctrl

Load/store unit controller for the MIPS CPU: accepts one memory request at a time from the execute stage and sequences it onto the Avalon-style data bus. It generates the aligned word address, byte enables and lane-replicated write data, and holds the request across `mem_waitrequest` stalls. It then extracts the addressed byte or halfword from read data and sign- or zero-extends it to 32 bits, returning the result to the register-writeback path. Misaligned accesses are detected before any bus activity and are reported as errors.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, bus data width; fixed at 32, other values unsupported

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept; request accepted when `req_valid && req_ready`
- `req_op`  in  3  operation: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  32  store data, right-aligned
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors
- `rsp_err`  out  1  misaligned access, valid with `rsp_valid`
- `mem_address`  out  ADDR_W  word-aligned address, bits [1:0] always 0
- `mem_read`  out  1  bus read strobe
- `mem_write`  out  1  bus write strobe
- `mem_byteenable`  out  4  active byte lanes
- `mem_writedata`  out  32  lane-replicated store data
- `mem_readdata`  in  32  bus read data, valid in the cycle `mem_waitrequest` is low with `mem_read` high
- `mem_waitrequest`  in  1  slave stall

## Operation
- States: IDLE, BUS, RESP.
- `req_ready` = (state == IDLE).
- IDLE, on acceptance:
  - Register op, addr and wdata.
  - Misaligned cases: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. These go to RESP with err=1 and never assert the bus strobes.
  - All other requests go to BUS.
- BUS:
  - Assert `mem_read` (loads) or `mem_write` (stores), holding address, byteenable and writedata stable.
  - Stay in BUS while `mem_waitrequest`=1.
  - When `mem_waitrequest`=0: capture the processed read data and go to RESP.
- RESP:
  - `rsp_valid`=1 for exactly one cycle, then return to IDLE.
  - No backpressure on the response; the CPU stalls on `req_ready`.
- Byte enables:
  - Byte ops: 1<<addr[1:0].
  - Half ops: addr[1] ? 4'b1100 : 4'b0011.
  - Word ops: 4'b1111.
- Write data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load path (little-endian lanes, lane k = bits [8k+7:8k]):
  - Shift readdata right by 8*addr[1:0].
  - LB sign-extends bit 7; LBU zero-extends 8 bits.
  - LH sign-extends bit 15; LHU zero-extends 16 bits.
  - LW passes the word through.
- Reset (asynchronous, any state, including mid-BUS):
  - state=IDLE.
  - `req_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `mem_read`=0, `mem_write`=0.
  - `mem_address`=0, `mem_byteenable`=0, `mem_writedata`=0.
  - An abandoned bus cycle is not retried.

## Timing
- Request accepted at edge N.
- Bus strobe is high during cycle N+1.
- With zero wait states, `rsp_valid` is high in cycle N+2.
- Each wait cycle adds one cycle of latency.
- Error path: `rsp_valid` in cycle N+1, with no strobe asserted.
- Bus outputs are registered. Outside BUS: strobes=0, byteenable=0.
- Minimum request spacing is 3 cycles (IDLE→BUS→RESP→IDLE), so back-to-back requests cannot overlap.
- `rsp_rdata` and `rsp_err` are meaningful only while `rsp_valid`=1. They read 0 otherwise.

## Structure
- `mips_lsu_pkg`:
  - `lsu_op_t` enum (values above).
  - `lsu_state_t` enum.
  - Functions `lsu_byteenable(op, addr)` and `lsu_misaligned(op, addr)`.
- Sub-module `mips_cpu_lsu_load_align`: combinational lane shift plus sign/zero extension (inputs readdata, addr[1:0], op; output 32-bit data). The FSM stays in the top module.

## Test plan
- LB, addr 0x1003, readdata 0x80_12_34_56, no wait:
  - byteenable 4'b1000, `mem_address` 0x1000.
  - `rsp_rdata` 0xFFFFFF80, `rsp_valid` in cycle N+2.
- LHU, addr 0x2002, readdata 0xBEEF0000, `mem_waitrequest` high for 3 cycles:
  - `mem_read` held 4 cycles.
  - `rsp_rdata` 0x0000BEEF at N+5.
- SB, addr 0x3001, wdata 0x000000A5:
  - `mem_write`=1, byteenable 4'b0010, writedata 0xA5A5A5A5.
  - `rsp_rdata` 0, `rsp_err` 0.
- LW, addr 0x4002:
  - No strobe asserted.
  - `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0 at N+1.
- Reset mid-op: `reset_n` low during BUS with `mem_waitrequest`=1:
  - Strobes drop immediately (asynchronously).
  - After release, `req_ready`=1 and no `rsp_valid` is produced.
- Back-to-back: LH at 0x10 (readdata 0x00008001) followed by SH at 0x12 (wdata 0x1234):
  - First response 0xFFFF8001.
  - Second request accepted in the cycle after RESP; byteenable 4'b1100, writedata 0x12341234.
